// File: rtl/aes_xts_pkg.sv
// aes_xts_pkg: shared AES/XTS constants, round-key store FSM encoding.
// Exports AES_BLOCK_W, AES256_NUM_RK, RK_IDX_W, rks_state_e, rk_step().
package aes_xts_pkg;

  localparam int AES_BLOCK_W   = 128;
  localparam int AES256_NUM_RK = 15;
  localparam int RK_IDX_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2,
    ST_READ  = 2'd3
  } rks_state_e;

  // Next round-key index in encrypt (up) or decrypt (down) order.
  function automatic logic [RK_IDX_W-1:0] rk_step(
    input logic [RK_IDX_W-1:0] idx,
    input logic                dec
  );
    return dec ? idx - 1'b1 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/aes_round_key_store_if.sv
// aes_round_key_store_if: key-load and round-key read bundle.
// master drives inKey*/inRd*, slave (the store) drives out*.
interface aes_round_key_store_if #(
  parameter int KEY_W = 128
);

  logic             inKeyStart;
  logic             inKeyValid;
  logic [KEY_W-1:0] inKey;
  logic             inRdStart;
  logic             inRdDecrypt;
  logic [KEY_W-1:0] outRoundKey;
  logic             outRoundKeyValid;
  logic [3:0]       outRoundIdx;
  logic             outLastRound;
  logic             outKeysReady;
  logic             outBusy;

  modport master (
    output inKeyStart, inKeyValid, inKey,
    output inRdStart, inRdDecrypt,
    input  outRoundKey, outRoundKeyValid,
    input  outRoundIdx, outLastRound,
    input  outKeysReady, outBusy
  );

  modport slave (
    input  inKeyStart, inKeyValid, inKey,
    input  inRdStart, inRdDecrypt,
    output outRoundKey, outRoundKeyValid,
    output outRoundIdx, outLastRound,
    output outKeysReady, outBusy
  );

endinterface

// File: rtl/aes_round_key_rf.sv
// aes_round_key_rf: NUM_RK x KEY_W round-key storage, 1W/1R, registered read.
// Ports: clk, rst, i_we/i_wr_addr/i_wr_data, i_re/i_rd_addr, o_rd_data,
// i_clr (only with AES_RKS_ZEROIZE_EN).
module aes_round_key_rf
  import aes_xts_pkg::*;
#(
  parameter int KEY_W  = AES_BLOCK_W,
  parameter int NUM_RK = AES256_NUM_RK
) (
  input  logic                clk,
  input  logic                rst,
`ifdef AES_RKS_ZEROIZE_EN
  input  logic                i_clr,
`endif
  input  logic                i_we,
  input  logic [RK_IDX_W-1:0] i_wr_addr,
  input  logic [KEY_W-1:0]    i_wr_data,
  input  logic                i_re,
  input  logic [RK_IDX_W-1:0] i_rd_addr,
  output logic [KEY_W-1:0]    o_rd_data
);

  logic [KEY_W-1:0] r_mem [NUM_RK];
  logic [KEY_W-1:0] r_rd_data;
  logic             w_clr;

`ifdef AES_RKS_ZEROIZE_EN
  assign w_clr = i_clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_RK; i++) r_mem[i] <= '0;
    end else if (w_clr) begin
      for (int i = 0; i < NUM_RK; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end
`else
  assign w_clr = 1'b0;

  // Key material survives reset; only a reload replaces it.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_wr_addr] <= i_wr_data;
  end
`endif

  // Output flop holds the last key read while no read is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_rd_data <= '0;
    else if (w_clr) r_rd_data <= '0;
    else if (i_re)  r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/aes_round_key_store.sv
// aes_round_key_store: captures AES-256 round keys, replays them in order.
// Ports: inClk, inRst, bus (aes_round_key_store_if.slave);
// inZeroize only when AES_RKS_ZEROIZE_EN is defined.
module aes_round_key_store
  import aes_xts_pkg::*;
#(
  parameter int KEY_W  = AES_BLOCK_W,
  parameter int NUM_RK = AES256_NUM_RK
) (
  input  logic inClk,
  input  logic inRst,
`ifdef AES_RKS_ZEROIZE_EN
  input  logic inZeroize,
`endif
  aes_round_key_store_if.slave bus
);

  localparam logic [RK_IDX_W-1:0] LAST = RK_IDX_W'(NUM_RK - 1);

  rks_state_e          r_state;
  logic [RK_IDX_W-1:0] r_wr_ptr;
  logic [RK_IDX_W-1:0] r_idx;
  logic                r_dec;
  logic                r_valid;
  logic                r_last;
  logic                r_ready;
  logic                r_busy;

  logic                w_zero;
  logic                w_kst;
  logic [RK_IDX_W-1:0] w_wr_idx;
  logic                w_we;
  logic                w_wr_last;
  logic                w_rd_go;
  logic                w_rd_step;
  logic                w_re;
  logic                w_dec;
  logic [RK_IDX_W-1:0] w_rd_addr;
  logic [RK_IDX_W-1:0] w_rd_end;
  logic                w_rd_last;
  logic [KEY_W-1:0]    w_rd_data;

`ifdef AES_RKS_ZEROIZE_EN
  assign w_zero = inZeroize;
`else
  assign w_zero = 1'b0;
`endif

  // Zeroize outranks a key start; a key start outranks any read.
  assign w_kst     = bus.inKeyStart & ~w_zero;
  assign w_wr_idx  = bus.inKeyStart ? '0 : r_wr_ptr;
  assign w_we      = ~w_zero & bus.inKeyValid &
                     (bus.inKeyStart | (r_state == ST_LOAD));
  assign w_wr_last = (w_wr_idx == LAST);

  // A new read may start from READY or on the final key of a read.
  assign w_rd_go   = ~w_zero & ~bus.inKeyStart & bus.inRdStart &
                     ((r_state == ST_READY) |
                      ((r_state == ST_READ) & r_last));
  assign w_rd_step = ~w_zero & ~bus.inKeyStart &
                     (r_state == ST_READ) & ~r_last;
  assign w_re      = w_rd_go | w_rd_step;
  assign w_dec     = w_rd_go ? bus.inRdDecrypt : r_dec;
  assign w_rd_addr = w_rd_go ? (bus.inRdDecrypt ? LAST : '0)
                             : rk_step(r_idx, r_dec);
  assign w_rd_end  = w_dec ? '0 : LAST;
  assign w_rd_last = (w_rd_addr == w_rd_end);

  aes_round_key_rf #(
    .KEY_W  (KEY_W),
    .NUM_RK (NUM_RK)
  ) u_rf (
    .clk       (inClk),
    .rst       (inRst),
`ifdef AES_RKS_ZEROIZE_EN
    .i_clr     (inZeroize),
`endif
    .i_we      (w_we),
    .i_wr_addr (w_wr_idx),
    .i_wr_data (bus.inKey),
    .i_re      (w_re),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge inClk or posedge inRst) begin
    if (inRst) begin
      r_state  <= ST_IDLE;
      r_wr_ptr <= '0;
      r_idx    <= '0;
      r_dec    <= 1'b0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_ready  <= 1'b0;
      r_busy   <= 1'b0;
    end else if (w_zero) begin
      r_state  <= ST_IDLE;
      r_wr_ptr <= '0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_ready  <= 1'b0;
      r_busy   <= 1'b0;
    end else if (w_kst) begin
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_wr_ptr <= bus.inKeyValid ? RK_IDX_W'(1) : '0;
      if (bus.inKeyValid && w_wr_last) begin
        r_state <= ST_READY;
        r_ready <= 1'b1;
        r_busy  <= 1'b0;
      end else begin
        r_state <= ST_LOAD;
        r_ready <= 1'b0;
        r_busy  <= 1'b1;
      end
    end else begin
      unique case (r_state)
        ST_IDLE: ;
        ST_LOAD: begin
          if (bus.inKeyValid) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_wr_last) begin
              r_state <= ST_READY;
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
            end
          end
        end
        ST_READY, ST_READ: begin
          if (w_rd_go) begin
            r_state <= ST_READ;
            r_busy  <= 1'b1;
            r_valid <= 1'b1;
            r_idx   <= w_rd_addr;
            r_dec   <= bus.inRdDecrypt;
            r_last  <= w_rd_last;
          end else if (w_rd_step) begin
            r_idx   <= w_rd_addr;
            r_last  <= w_rd_last;
          end else if (r_state == ST_READ) begin
            r_state <= ST_READY;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.outRoundKey      = w_rd_data;
  assign bus.outRoundKeyValid = r_valid;
  assign bus.outRoundIdx      = r_idx;
  assign bus.outLastRound     = r_last;
  assign bus.outKeysReady     = r_ready;
  assign bus.outBusy          = r_busy;

endmodule

// File: tb/tb_aes_round_key_store.sv
// tb_aes_round_key_store: directed/random bench for aes_round_key_store.
// Reference is a plain key array plus read-order arithmetic.
module tb_aes_round_key_store;

  logic clk;
  logic rst;
`ifdef AES_RKS_ZEROIZE_EN
  logic zeroize;
`endif

  aes_round_key_store_if #(.KEY_W(128)) bus ();

  aes_round_key_store #(.KEY_W(128), .NUM_RK(15)) dut (
    .inClk     (clk),
    .inRst     (rst),
`ifdef AES_RKS_ZEROIZE_EN
    .inZeroize (zeroize),
`endif
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [127:0] mem [15];

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Load words first..last; word 0 carries inKeyStart.
  task automatic load_words(input int first, input int last,
                            input bit rnd, input bit rd_w_start);
    for (int i = first; i <= last; i++) begin
      logic [127:0] k;
      k = rnd ? rnd128() : {16{8'(i)}};
      bus.inKeyStart = (i == 0);
      bus.inKeyValid = 1'b1;
      bus.inKey      = k;
      bus.inRdStart  = (i == 3) || (i == 0 && rd_w_start);
      mem[i] = k;
      tick();
      bus.inKeyStart = 1'b0;
      bus.inRdStart  = 1'b0;
      chk("load_valid", 128'(bus.outRoundKeyValid), 128'(0));
      chk("load_busy", 128'(bus.outBusy), 128'(i < 14));
      chk("load_ready", 128'(bus.outKeysReady), 128'(i == 14));
    end
    bus.inKeyValid = 1'b0;
  endtask

  // One read (or two chained back-to-back) checked against mem[].
  task automatic rd_seq(input logic d0, input bit chain, input logic d1);
    int n;
    int k;
    int idx;
    logic d;
    n = chain ? 30 : 15;
    bus.inRdStart   = 1'b1;
    bus.inRdDecrypt = d0;
    tick();
    bus.inRdStart = 1'b0;
    for (int j = 0; j < n; j++) begin
      k   = j % 15;
      d   = (j < 15) ? d0 : d1;
      idx = d ? 14 - k : k;
      chk("rd_valid", 128'(bus.outRoundKeyValid), 128'(1));
      chk("rd_idx", 128'(bus.outRoundIdx), 128'(idx));
      chk("rd_key", bus.outRoundKey, mem[idx]);
      chk("rd_last", 128'(bus.outLastRound), 128'(k == 14));
      chk("rd_busy", 128'(bus.outBusy), 128'(1));
      if (chain && j == 14) begin
        bus.inRdStart   = 1'b1;
        bus.inRdDecrypt = d1;
      end else if (!chain && j == 5) begin
        bus.inRdStart   = 1'b1;
        bus.inRdDecrypt = ~d0;
      end
      tick();
      bus.inRdStart = 1'b0;
    end
    d = chain ? d1 : d0;
    chk("rd_end_valid", 128'(bus.outRoundKeyValid), 128'(0));
    chk("rd_end_last", 128'(bus.outLastRound), 128'(0));
    chk("rd_end_busy", 128'(bus.outBusy), 128'(0));
    chk("rd_end_ready", 128'(bus.outKeysReady), 128'(1));
    chk("rd_hold_key", bus.outRoundKey, mem[d ? 0 : 14]);
  endtask

  initial begin
    logic [127:0] held;
    rst = 1'b1;
`ifdef AES_RKS_ZEROIZE_EN
    zeroize = 1'b0;
`endif
    bus.inKeyStart  = 1'b0;
    bus.inKeyValid  = 1'b0;
    bus.inKey       = '0;
    bus.inRdStart   = 1'b0;
    bus.inRdDecrypt = 1'b0;
    tick();
    tick();
    chk("rst_valid", 128'(bus.outRoundKeyValid), 128'(0));
    chk("rst_last", 128'(bus.outLastRound), 128'(0));
    chk("rst_ready", 128'(bus.outKeysReady), 128'(0));
    chk("rst_busy", 128'(bus.outBusy), 128'(0));
    chk("rst_idx", 128'(bus.outRoundIdx), 128'(0));
    chk("rst_key", bus.outRoundKey, 128'(0));
    rst = 1'b0;
    tick();

    // Read request while IDLE.
    bus.inRdStart = 1'b1;
    tick();
    bus.inRdStart = 1'b0;
    chk("idle_rd_valid", 128'(bus.outRoundKeyValid), 128'(0));
    chk("idle_rd_busy", 128'(bus.outBusy), 128'(0));
    tick();
    chk("idle_rd_valid2", 128'(bus.outRoundKeyValid), 128'(0));

    load_words(0, 14, 1'b0, 1'b0);
    rd_seq(1'b0, 1'b0, 1'b0);
    tick();
    rd_seq(1'b1, 1'b1, 1'b0);

    // Stray key words while READY must not disturb storage.
    bus.inKeyValid = 1'b1;
    bus.inKey      = '1;
    tick();
    tick();
    tick();
    bus.inKeyValid = 1'b0;
    chk("stray_ready", 128'(bus.outKeysReady), 128'(1));
    rd_seq(1'b0, 1'b0, 1'b0);

    // Abort a read with a fresh key start at read cycle 5.
    load_words(0, 14, 1'b1, 1'b0);
    bus.inRdStart   = 1'b1;
    bus.inRdDecrypt = 1'b0;
    tick();
    bus.inRdStart = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      chk("ab_idx", 128'(bus.outRoundIdx), 128'(k));
      chk("ab_key", bus.outRoundKey, mem[k]);
      if (k < 5) tick();
    end
    held = mem[5];
    mem[0] = rnd128();
    bus.inKeyStart = 1'b1;
    bus.inKeyValid = 1'b1;
    bus.inKey      = mem[0];
    tick();
    bus.inKeyStart = 1'b0;
    bus.inKeyValid = 1'b0;
    chk("ab_valid", 128'(bus.outRoundKeyValid), 128'(0));
    chk("ab_ready", 128'(bus.outKeysReady), 128'(0));
    chk("ab_busy", 128'(bus.outBusy), 128'(1));
    chk("ab_hold", bus.outRoundKey, held);
    bus.inRdStart = 1'b1;
    tick();
    bus.inRdStart = 1'b0;
    chk("ab_rd_ign", 128'(bus.outRoundKeyValid), 128'(0));
    load_words(1, 14, 1'b1, 1'b0);
    rd_seq(1'b1, 1'b0, 1'b0);

    // Key start coinciding with a read request wins.
    tick();
    load_words(0, 14, 1'b1, 1'b1);
    rd_seq(1'b0, 1'b1, 1'b1);

    // Reset in the middle of a load.
    load_words(0, 6, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    chk("mrst_valid", 128'(bus.outRoundKeyValid), 128'(0));
    chk("mrst_last", 128'(bus.outLastRound), 128'(0));
    chk("mrst_ready", 128'(bus.outKeysReady), 128'(0));
    chk("mrst_busy", 128'(bus.outBusy), 128'(0));
    chk("mrst_idx", 128'(bus.outRoundIdx), 128'(0));
    chk("mrst_key", bus.outRoundKey, 128'(0));
    tick();
    rst = 1'b0;
    bus.inKeyValid = 1'b1;
    bus.inRdStart  = 1'b1;
    tick();
    bus.inKeyValid = 1'b0;
    bus.inRdStart  = 1'b0;
    chk("mrst_rd_valid", 128'(bus.outRoundKeyValid), 128'(0));
    chk("mrst_rd_busy", 128'(bus.outBusy), 128'(0));
    chk("mrst_rd_ready", 128'(bus.outKeysReady), 128'(0));

`ifdef AES_RKS_ZEROIZE_EN
    load_words(0, 14, 1'b1, 1'b0);
    zeroize        = 1'b1;
    bus.inKeyStart = 1'b1;
    tick();
    zeroize        = 1'b0;
    bus.inKeyStart = 1'b0;
    chk("zer_ready", 128'(bus.outKeysReady), 128'(0));
    chk("zer_busy", 128'(bus.outBusy), 128'(0));
    chk("zer_valid", 128'(bus.outRoundKeyValid), 128'(0));
    for (int i = 0; i < 15; i++) begin
      chk("zer_entry", dut.u_rf.r_mem[i], 128'(0));
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
